genius_input_capture: RTL and testbench

- Player-input front end for the Genius game FSM, directly upstream of it.
- Synchronises and debounces the three pushbuttons bt0..bt2, converts presses into single-cycle key events with a 2-bit symbol code, and compares each event against the symbol the FSM expects.
- Provides the response-timeout pulse used during the receiveInputs state.

---
 rtl/genius_input_capture.sv | 120 ++++++++++++
 tb/tb_genius_input_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_input_capture.sv
//------------------------------------------------------------------------------
// Module      : genius_input_capture
// Description : Pushbutton front end for the Genius game FSM. Synchronises and
//               debounces bt0..bt2, emits single-cycle key events with a symbol
//               code and match flag, and generates the response-timeout pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module genius_input_capture #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 250000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bt0,
    input  logic       bt1,
    input  logic       bt2,
    input  logic       enable,
    input  logic [1:0] expected,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       key_match,
    output logic       timeout,
    output logic [2:0] held
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES  > 2) ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam logic [DW-1:0] C_DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] C_TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    held_q, held_d, held_prev_q;
    logic [DW-1:0] db_cnt_q [3];
    logic [DW-1:0] db_cnt_d [3];
    logic          armed_q;
    logic          key_valid_q, key_match_q, timeout_q;
    logic [1:0]    key_code_q;
    logic [TW-1:0] to_cnt_q;

    logic [2:0]    rise_w;
    logic          onehot_w;
    logic          accept_w;
    logic [1:0]    code_w;

    // Counter restarts whenever the synchronised level agrees with held.
    for (genvar i = 0; i < 3; i++) begin : g_debounce
        assign held_d[i]   = (sync2_q[i] != held_q[i]) && (db_cnt_q[i] == C_DB_MAX)
                             ? ~held_q[i] : held_q[i];
        assign db_cnt_d[i] = ((sync2_q[i] == held_q[i]) || (db_cnt_q[i] == C_DB_MAX))
                             ? '0 : db_cnt_q[i] + DW'(1);
    end

    assign rise_w   = held_q & ~held_prev_q;
    assign onehot_w = (rise_w == 3'b001) || (rise_w == 3'b010) || (rise_w == 3'b100);
    // Requiring held == rise also rejects a press while another button is down.
    assign accept_w = enable && armed_q && onehot_w && (held_q == rise_w);

    always_comb begin
        code_w = 2'b00;
        if (rise_w[1]) begin
            code_w = 2'b01;
        end else if (rise_w[2]) begin
            code_w = 2'b10;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            held_q      <= '0;
            held_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            armed_q     <= 1'b1;
            key_valid_q <= 1'b0;
            key_code_q  <= 2'b00;
            key_match_q <= 1'b0;
            timeout_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            sync1_q     <= ~{bt2, bt1, bt0};
            sync2_q     <= sync1_q;
            held_q      <= held_d;
            held_prev_q <= held_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            armed_q     <= (held_q == 3'b000);
            key_valid_q <= accept_w;
            key_match_q <= accept_w && (code_w == expected);
            if (accept_w) begin
                key_code_q <= code_w;
            end

            if (!enable || accept_w) begin
                to_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else if (to_cnt_q == C_TO_MAX) begin
                to_cnt_q  <= '0;
                timeout_q <= 1'b1;
            end else begin
                to_cnt_q  <= to_cnt_q + TW'(1);
                timeout_q <= 1'b0;
            end
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_match = key_match_q;
    assign timeout   = timeout_q;
    assign held      = held_q;

endmodule

`default_nettype wire

// File: tb/tb_genius_input_capture.sv
//------------------------------------------------------------------------------
// Module      : tb_genius_input_capture
// Description : Scoreboard bench for genius_input_capture (DEBOUNCE=4, TIMEOUT=100).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_genius_input_capture;

    localparam int DB  = 4;
    localparam int TO  = 100;
    localparam int LAT = DB + 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       bt0, bt1, bt2;
    logic       enable;
    logic [1:0] expected;
    logic       key_valid;
    logic [1:0] key_code;
    logic       key_match;
    logic       timeout;
    logic [2:0] held;

    genius_input_capture #(
        .DEBOUNCE_CYCLES (DB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bt0       (bt0),
        .bt1       (bt1),
        .bt2       (bt2),
        .enable    (enable),
        .expected  (expected),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_match (key_match),
        .timeout   (timeout),
        .held      (held)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [1:0] code;
        logic       match;
    } ev_t;

    ev_t  exp_q [$];
    int   tmo_q [$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_ev(input int lat_from_now, input logic [1:0] code, input logic match);
        ev_t e;
        e.cyc   = cyc + lat_from_now;
        e.code  = code;
        e.match = match;
        exp_q.push_back(e);
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'(key_valid), 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.cyc));
                    check("event_code", 32'(key_code), 32'(e.code));
                    check("event_match", 32'(key_match), 32'(e.match));
                end
            end else if (key_match) begin
                check("match_unqualified", 32'(key_match), 32'd0);
            end
            if (timeout) begin
                if (tmo_q.size() == 0) begin
                    check("unexpected_timeout", 32'(timeout), 32'd0);
                end else begin
                    check("timeout_cycle", 32'(cyc), 32'(tmo_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        reset_n  = 1'b0;
        bt0      = 1'b1;
        bt1      = 1'b1;
        bt2      = 1'b1;
        enable   = 1'b0;
        expected = 2'b00;
        tick(3);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code",  32'(key_code),  32'd0);
        check("rst_key_match", 32'(key_match), 32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        check("rst_held",      32'(held),      32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(200);
        check("idle_held", 32'(held), 32'd0);
        check("idle_key_code", 32'(key_code), 32'd0);

        // bt1 press with a matching expectation
        enable   = 1'b1;
        expected = 2'b01;
        bt1      = 1'b0;
        push_ev(LAT, 2'b01, 1'b1);
        tick(8);
        check("held_bt1", 32'(held), 32'b010);
        tick(12);
        bt1 = 1'b1;
        tick(10);
        check("held_bt1_released", 32'(held), 32'd0);
        check("code_holds", 32'(key_code), 32'b01);
        enable = 1'b0;
        tick(5);

        // bt2 press against a mismatching expectation
        enable   = 1'b1;
        expected = 2'b00;
        bt2      = 1'b0;
        push_ev(LAT, 2'b10, 1'b0);
        tick(12);
        bt2 = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(5);

        // bounce shorter than the debounce window
        enable = 1'b1;
        bt0    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("glitch_held", 32'(held), 32'd0);
        end
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) bt0 = ~bt0;
            tick(1);
            check("bounce_held", 32'(held), 32'd0);
        end
        bt0 = 1'b1;
        tick(10);
        check("bounce_settled", 32'(held), 32'd0);
        enable = 1'b0;
        tick(5);

        // simultaneous pair is rejected, later single press is accepted
        enable   = 1'b1;
        expected = 2'b00;
        bt0      = 1'b0;
        bt2      = 1'b0;
        tick(12);
        check("held_pair", 32'(held), 32'b101);
        bt0 = 1'b1;
        bt2 = 1'b1;
        tick(10);
        bt0 = 1'b0;
        push_ev(LAT, 2'b00, 1'b1);
        tick(12);
        bt0 = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(5);

        // free-running timeout
        enable = 1'b1;
        t0     = cyc;
        tmo_q.push_back(t0 + TO);
        tmo_q.push_back(t0 + 2 * TO);
        tick(250);
        enable = 1'b0;
        tick(5);

        // accepted press restarts the timeout window
        enable = 1'b1;
        t0     = cyc;
        tmo_q.push_back(t0 + TO);
        tick(150);
        bt0 = 1'b0;
        push_ev(LAT, 2'b00, 1'b1);
        tmo_q.push_back(t0 + 150 + LAT + TO);
        tick(20);
        bt0 = 1'b1;
        tick(95);
        enable = 1'b0;
        tick(5);

        // asynchronous reset while a button is held
        enable   = 1'b1;
        expected = 2'b01;
        bt1      = 1'b0;
        push_ev(LAT, 2'b01, 1'b1);
        tick(10);
        check("held_before_rst", 32'(held), 32'b010);
        enable  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_held", 32'(held), 32'd0);
        check("async_rst_code", 32'(key_code), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(12);
        check("held_after_rst", 32'(held), 32'b010);
        enable = 1'b1;
        tick(20);
        check("no_event_code", 32'(key_code), 32'd0);
        bt1 = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(5);

        check("events_pending", 32'(exp_q.size()), 32'd0);
        check("timeouts_pending", 32'(tmo_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
